// File: rtl/body_update_sequencer.sv
// Three-body update controller: walks pairs AB, AC, BC through one shared
// distance unit, accumulates forces, then commits velocities/positions at once.
module body_update_sequencer #(
    parameter int NEAR_THR = 40,
    parameter int FAR_AB   = 300,
    parameter int FAR_AC   = 200,
    parameter int FAR_BC   = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic signed [9:0] ax_o,
    output logic signed [9:0] ay_o,
    output logic signed [9:0] bx_o,
    output logic signed [9:0] by_o,
    output logic signed [9:0] cx_o,
    output logic signed [9:0] cy_o,
    output logic              busy,
    output logic              done,
    output logic              missed_start,
    output logic [9:0]        frame_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_DIST_X, S_DIST_Y, S_FORCE, S_COMMIT, S_DONE
    } state_t;

    localparam logic [9:0] RST_X [3] = '{10'd300, 10'd420, 10'd200};
    localparam logic [9:0] RST_Y [3] = '{10'd150, 10'd300, 10'd20};

    state_t      state_q, state_d;
    logic [1:0]  pair_q;
    logic [1:0]  idx_i, idx_j;
    logic [10:0] absx_q, dist_q, far_thr;
    logic        sx_q, sy_q;
    logic [9:0]  frame_count_q;
    logic        missed_q;

    logic [2:0][9:0] pos_x_w, pos_y_w;
    logic [9:0]  op_i, op_j;
    logic [10:0] diff, diff_abs;
    logic [3:0]  mag, force_x, force_y;

    // Pair decode: (i, j) with i the first letter of the pair.
    always_comb begin
        idx_i   = 2'd0;
        idx_j   = 2'd1;
        far_thr = 11'(FAR_AB);
        case (pair_q)
            2'd0:    begin idx_i = 2'd0; idx_j = 2'd1; far_thr = 11'(FAR_AB); end
            2'd1:    begin idx_i = 2'd0; idx_j = 2'd2; far_thr = 11'(FAR_AC); end
            default: begin idx_i = 2'd1; idx_j = 2'd2; far_thr = 11'(FAR_BC); end
        endcase
    end

    // Shared distance unit: x operands in DIST_X, y operands otherwise.
    always_comb begin
        op_i     = (state_q == S_DIST_X) ? pos_x_w[idx_i] : pos_y_w[idx_i];
        op_j     = (state_q == S_DIST_X) ? pos_x_w[idx_j] : pos_y_w[idx_j];
        diff     = {op_j[9], op_j} - {op_i[9], op_i};
        diff_abs = diff[10] ? (~diff + 11'd1) : diff;
    end

    always_comb begin
        if (dist_q < 11'(NEAR_THR))
            mag = 4'd2;
        else if (dist_q < far_thr)
            mag = 4'd1;
        else
            mag = 4'd0;
        force_x = sx_q ? (4'd0 - mag) : mag;
        force_y = sy_q ? (4'd0 - mag) : mag;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_DIST_X;
            S_DIST_X: state_d = S_DIST_Y;
            S_DIST_Y: state_d = S_FORCE;
            S_FORCE:  state_d = (pair_q == 2'd2) ? S_COMMIT : S_DIST_X;
            S_COMMIT: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pair_q        <= 2'd0;
            absx_q        <= '0;
            dist_q        <= '0;
            sx_q          <= 1'b0;
            sy_q          <= 1'b0;
            frame_count_q <= '0;
            missed_q      <= 1'b0;
        end else begin
            if (start && state_q != S_IDLE)
                missed_q <= 1'b1;
            case (state_q)
                S_IDLE:   if (start) pair_q <= 2'd0;
                S_DIST_X: begin
                    absx_q <= diff_abs;
                    sx_q   <= diff[10];
                end
                S_DIST_Y: begin
                    sy_q   <= diff[10];
                    dist_q <= absx_q + diff_abs;
                end
                S_FORCE:  if (pair_q != 2'd2) pair_q <= pair_q + 2'd1;
                S_COMMIT: frame_count_q <= frame_count_q + 10'd1;
                default:  ;
            endcase
        end
    end

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_body
        logic [9:0] pos_x_q, pos_y_q, vel_x_q, vel_y_q;
        logic [3:0] acc_x_q, acc_y_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                pos_x_q <= RST_X[gi];
                pos_y_q <= RST_Y[gi];
                vel_x_q <= '0;
                vel_y_q <= '0;
                acc_x_q <= '0;
                acc_y_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: if (start) begin
                        acc_x_q <= '0;
                        acc_y_q <= '0;
                    end
                    S_FORCE: begin
                        if (idx_i == 2'(gi)) begin
                            acc_x_q <= acc_x_q + force_x;
                            acc_y_q <= acc_y_q + force_y;
                        end else if (idx_j == 2'(gi)) begin
                            acc_x_q <= acc_x_q - force_x;
                            acc_y_q <= acc_y_q - force_y;
                        end
                    end
                    // Positions advance with the velocity held before this commit.
                    S_COMMIT: begin
                        vel_x_q <= vel_x_q + {{6{acc_x_q[3]}}, acc_x_q};
                        vel_y_q <= vel_y_q + {{6{acc_y_q[3]}}, acc_y_q};
                        pos_x_q <= pos_x_q + vel_x_q;
                        pos_y_q <= pos_y_q + vel_y_q;
                    end
                    default: ;
                endcase
            end
        end

        assign pos_x_w[gi] = pos_x_q;
        assign pos_y_w[gi] = pos_y_q;
    end

    assign ax_o         = pos_x_w[0];
    assign ay_o         = pos_y_w[0];
    assign bx_o         = pos_x_w[1];
    assign by_o         = pos_y_w[1];
    assign cx_o         = pos_x_w[2];
    assign cy_o         = pos_y_w[2];
    assign frame_count  = frame_count_q;
    assign missed_start = missed_q;

endmodule
